// File: rtl/sd_data_rx.sv
// SD read-data receiver: 1/4/8 lanes, per-lane CRC16 check, bytes packed into WORD_W-bit FIFO words.
// Latency: fifoWe one cycle after a word's last bit; done one cycle after the end bit (or after start on cfgErr).
// Backpressure: fifoAlmostFull sampled at block boundaries only; HOLD raises sdClkStop until it clears.
module sd_data_rx #(
    parameter int MAX_LANES = 4,
    parameter int WORD_W    = 64,
    parameter int BLKLEN_W  = 12,
    parameter int BLKCNT_W  = 16,
    parameter int TIMEOUT_W = 24
) (
    input  logic                 sdClk,
    input  logic                 sysRst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [1:0]           busWidth,
    input  logic [BLKLEN_W-1:0]  blockLen,
    input  logic [BLKCNT_W-1:0]  blockCount,
    input  logic [TIMEOUT_W-1:0] timeoutCycles,
    input  logic [MAX_LANES-1:0] sdDataIn,
    input  logic                 fifoAlmostFull,
    output logic                 fifoWe,
    output logic [WORD_W-1:0]    fifoData,
    output logic                 sdClkStop,
    output logic                 busy,
    output logic                 done,
    output logic                 crcErr,
    output logic                 timeoutErr,
    output logic                 cfgErr
);
    localparam int BITCNT_W   = BLKLEN_W + 3;
    localparam int WBIT_W     = $clog2(WORD_W + 1);
    localparam int WORD_BYTES = WORD_W / 8;

    typedef enum logic [2:0] {IDLE, WAIT_START, DATA, CRC, END, HOLD} rxStateT;

    rxStateT              state, nextState;
    logic [1:0]           curWidth;
    logic [BLKLEN_W-1:0]  curLen;
    logic [BLKCNT_W-1:0]  blkLeft;
    logic [TIMEOUT_W-1:0] curTimeout, toCnt;
    logic [BITCNT_W-1:0]  bitCnt;
    logic [WBIT_W-1:0]    wordBits;
    logic [3:0]           crcCnt;
    logic [WORD_W-1:0]    shiftReg;
    logic [15:0]          crcReg [MAX_LANES];
    logic                 crcBad;

    logic [7:0] laneBits, laneMask;
    logic [3:0] laneStep;
    logic       laneOk, cfgBad, startBit, endOk, timeoutHit, lastData, wordEnd, crcMiss, blkBad;

    // Lane view zero-extended to 8, active-lane mask, and per-cycle decisions.
    always_comb begin
        laneBits = '0;
        laneBits[MAX_LANES-1:0] = sdDataIn;
        case (curWidth)
            2'b00:   begin laneMask = 8'h01; laneStep = 4'd1; end
            2'b01:   begin laneMask = 8'h0F; laneStep = 4'd4; end
            default: begin laneMask = 8'hFF; laneStep = 4'd8; end
        endcase
        case (busWidth)
            2'b00:   laneOk = 1'b1;
            2'b01:   laneOk = (MAX_LANES >= 4);
            2'b10:   laneOk = (MAX_LANES >= 8);
            default: laneOk = 1'b0;
        endcase
        cfgBad     = !laneOk || (blockLen == '0) || ((blockLen % BLKLEN_W'(WORD_BYTES)) != '0);
        startBit   = (laneBits & laneMask) == 8'h00;
        endOk      = (laneBits & laneMask) == laneMask;
        // toCnt counts from 0 at entry, so the limit is reached on cycle timeoutCycles.
        timeoutHit = (curTimeout != '0) &&
                     (({1'b0, toCnt} + (TIMEOUT_W+1)'(1)) == {1'b0, curTimeout});
        lastData   = (bitCnt + BITCNT_W'(laneStep)) == {curLen, 3'b000};
        wordEnd    = (wordBits + WBIT_W'(laneStep)) == WBIT_W'(WORD_W);
        crcMiss    = 1'b0;
        for (int i = 0; i < MAX_LANES; i++)
            crcMiss = crcMiss | (laneMask[i] & (laneBits[i] ^ crcReg[i][15]));
        blkBad     = crcBad || !endOk;
    end

    // State register.
    always_ff @(posedge sdClk or posedge sysRst) begin
        if (sysRst) state <= IDLE;
        else        state <= nextState;
    end

    // Next-state logic and state-decoded outputs; abort overrides every transition.
    always_comb begin
        nextState = state;
        busy      = (state != IDLE);
        sdClkStop = (state == HOLD) && fifoAlmostFull;
        case (state)
            IDLE:       if (start && !cfgBad) nextState = WAIT_START;
            WAIT_START: if (startBit) nextState = DATA;
                        else if (timeoutHit) nextState = IDLE;
            DATA:       if (lastData) nextState = CRC;
            CRC:        if (crcCnt == 4'd15) nextState = END;
            END:        if (blkBad || blkLeft == BLKCNT_W'(1)) nextState = IDLE;
                        else nextState = fifoAlmostFull ? HOLD : WAIT_START;
            HOLD:       if (!fifoAlmostFull) nextState = WAIT_START;
            default:    nextState = IDLE;
        endcase
        if (abort) nextState = IDLE;
    end

    // Datapath: config latch, shift/pack, per-lane CRC, counters, status pulses and flags.
    always_ff @(posedge sdClk or posedge sysRst) begin
        if (sysRst) begin
            curWidth <= '0; curLen <= '0; blkLeft <= '0; curTimeout <= '0; toCnt <= '0;
            bitCnt <= '0; wordBits <= '0; crcCnt <= '0; shiftReg <= '0; crcBad <= 1'b0;
            for (int i = 0; i < MAX_LANES; i++) crcReg[i] <= '0;
            fifoWe <= 1'b0; done <= 1'b0; crcErr <= 1'b0; timeoutErr <= 1'b0; cfgErr <= 1'b0;
        end else begin
            done   <= 1'b0;
            fifoWe <= 1'b0;
            // Timeout counter restarts whenever we are outside WAIT_START and saturates inside it.
            if (state == WAIT_START) begin
                if (toCnt != '1) toCnt <= toCnt + TIMEOUT_W'(1);
            end else begin
                toCnt <= '0;
            end
            if (!abort) begin
                case (state)
                    IDLE: if (start) begin
                        crcErr     <= 1'b0;
                        timeoutErr <= 1'b0;
                        cfgErr     <= cfgBad;
                        done       <= cfgBad;
                        curWidth   <= busWidth;
                        curLen     <= blockLen;
                        curTimeout <= timeoutCycles;
                        blkLeft    <= (blockCount == '0) ? BLKCNT_W'(1) : blockCount;
                    end
                    WAIT_START: begin
                        bitCnt   <= '0;
                        wordBits <= '0;
                        crcCnt   <= '0;
                        crcBad   <= 1'b0;
                        for (int i = 0; i < MAX_LANES; i++) crcReg[i] <= '0;
                        if (!startBit && timeoutHit) begin
                            done       <= 1'b1;
                            timeoutErr <= 1'b1;
                        end
                    end
                    DATA: begin
                        case (curWidth)
                            2'b00:   shiftReg <= {shiftReg[WORD_W-2:0], laneBits[0]};
                            2'b01:   shiftReg <= {shiftReg[WORD_W-5:0], laneBits[3:0]};
                            default: shiftReg <= {shiftReg[WORD_W-9:0], laneBits};
                        endcase
                        for (int i = 0; i < MAX_LANES; i++)
                            crcReg[i] <= {crcReg[i][14:0], 1'b0} ^
                                         ((laneBits[i] ^ crcReg[i][15]) ? 16'h1021 : 16'h0000);
                        bitCnt <= bitCnt + BITCNT_W'(laneStep);
                        if (wordEnd) begin
                            wordBits <= '0;
                            fifoWe   <= 1'b1;
                        end else begin
                            wordBits <= wordBits + WBIT_W'(laneStep);
                        end
                    end
                    CRC: begin
                        // Received CRC is compared bit-serially against the top of each lane's register.
                        crcCnt <= crcCnt + 4'd1;
                        crcBad <= crcBad | crcMiss;
                        for (int i = 0; i < MAX_LANES; i++) crcReg[i] <= {crcReg[i][14:0], 1'b0};
                    end
                    END: begin
                        blkLeft <= blkLeft - BLKCNT_W'(1);
                        if (blkBad) begin
                            done   <= 1'b1;
                            crcErr <= 1'b1;
                        end else if (blkLeft == BLKCNT_W'(1)) begin
                            done <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign fifoData = shiftReg;

endmodule

// File: tb/tb_sd_data_rx.sv
// Directed bench for sd_data_rx: card model drives lanes and CRCs, monitor counts words and done pulses.
// Latency: checks done/fifoWe timing at negedges relative to the end bit / start pulse.
// Backpressure: exercises HOLD via fifoAlmostFull at a block boundary.
module tb_sd_data_rx;
    logic        sdClk, sysRst, start, abort, fifoAlmostFull;
    logic [1:0]  busWidth;
    logic [11:0] blockLen;
    logic [15:0] blockCount;
    logic [23:0] timeoutCycles;
    logic [3:0]  sdDataIn;
    logic        fifoWe, sdClkStop, busy, done, crcErr, timeoutErr, cfgErr;
    logic [63:0] fifoData;

    int nCmp = 0;
    int nFail = 0;
    int weCnt = 0;
    int doneCnt = 0;
    logic [63:0] words [$];

    sd_data_rx dut (
        .sdClk(sdClk), .sysRst(sysRst), .start(start), .abort(abort),
        .busWidth(busWidth), .blockLen(blockLen), .blockCount(blockCount),
        .timeoutCycles(timeoutCycles), .sdDataIn(sdDataIn), .fifoAlmostFull(fifoAlmostFull),
        .fifoWe(fifoWe), .fifoData(fifoData), .sdClkStop(sdClkStop), .busy(busy),
        .done(done), .crcErr(crcErr), .timeoutErr(timeoutErr), .cfgErr(cfgErr)
    );

    always #5 sdClk = ~sdClk;

    // Word and completion monitor, sampled just after each rising edge.
    always @(posedge sdClk) begin
        #1;
        if (fifoWe) begin
            weCnt++;
            words.push_back(fifoData);
        end
        if (done) doneCnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nCmp++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] wordAt(input int i);
        if (i < words.size()) return words[i];
        return 64'hDEAD_DEAD_DEAD_DEAD;
    endfunction

    function automatic logic [15:0] crcStep(input logic [15:0] c, input logic d);
        logic [15:0] t;
        t = c ^ {d, 15'd0};
        return t[15] ? ((t << 1) ^ 16'h1021) : (t << 1);
    endfunction

    task automatic clearCounts();
        weCnt = 0;
        doneCnt = 0;
        words.delete();
    endtask

    // Pulse start, then scramble the config inputs to prove they were latched.
    task automatic doStart(input logic [1:0] bw, input int len, input int cnt, input int to);
        busWidth = bw; blockLen = 12'(len); blockCount = 16'(cnt); timeoutCycles = 24'(to);
        start = 1'b1;
        @(negedge sdClk);
        start = 1'b0;
        busWidth = 2'b11; blockLen = 12'd0; blockCount = 16'd0; timeoutCycles = 24'd7;
    endtask

    // Card model for one block: idle gap, start bit, data, per-lane CRC16, end bit.
    task automatic driveBlock(input int lanes, input int nBytes, input bit zeroData,
                              input int flipLane, input bit badEnd, input int gap);
        logic [15:0] c [4];
        logic [3:0]  mask, v;
        logic [7:0]  by;
        int nCyc;
        mask = (lanes == 1) ? 4'b0001 : 4'b1111;
        for (int j = 0; j < 4; j++) c[j] = 16'h0000;
        for (int g = 0; g < gap; g++) begin
            sdDataIn = 4'hF;
            @(negedge sdClk);
        end
        v = 4'($urandom);
        sdDataIn = v & ~mask;
        @(negedge sdClk);
        nCyc = nBytes * 8 / lanes;
        for (int k = 0; k < nCyc; k++) begin
            v = 4'($urandom);
            if (lanes == 1) begin
                by = zeroData ? 8'h00 : 8'(k / 8);
                v[0] = by[7 - (k % 8)];
            end else begin
                by = zeroData ? 8'h00 : 8'(k / 2);
                v = (k % 2 == 0) ? by[7:4] : by[3:0];
            end
            for (int j = 0; j < 4; j++)
                if (mask[j]) c[j] = crcStep(c[j], v[j]);
            sdDataIn = v;
            @(negedge sdClk);
        end
        for (int b = 15; b >= 0; b--) begin
            v = 4'($urandom);
            for (int j = 0; j < 4; j++)
                if (mask[j]) v[j] = c[j][b] ^ ((j == flipLane) && (b == 5));
            sdDataIn = v;
            @(negedge sdClk);
        end
        v = 4'($urandom);
        sdDataIn = badEnd ? (v & ~mask) : (v | mask);
        @(negedge sdClk);
        sdDataIn = 4'hF;
    endtask

    initial begin
        int hit;
        int stopCnt;
        sdClk = 1'b0; sysRst = 1'b1; start = 1'b0; abort = 1'b0; fifoAlmostFull = 1'b0;
        busWidth = 2'b00; blockLen = '0; blockCount = '0; timeoutCycles = '0; sdDataIn = 4'hF;

        // Reset state
        repeat (3) @(negedge sdClk);
        check("rst_fifoWe", fifoWe, 0);
        check("rst_fifoData", fifoData, 0);
        check("rst_sdClkStop", sdClkStop, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_errs", {crcErr, timeoutErr, cfgErr}, 0);
        sysRst = 1'b0;
        @(negedge sdClk);

        // 4-lane, 512-byte counter pattern, good CRC
        clearCounts();
        doStart(2'b01, 512, 1, 0);
        check("A_busy", busy, 1);
        driveBlock(4, 512, 1'b0, -1, 1'b0, 3);
        check("A_done", done, 1);
        check("A_doneCnt", doneCnt, 1);
        check("A_errs", {crcErr, timeoutErr, cfgErr}, 3'b000);
        check("A_busy_end", busy, 0);
        check("A_weCnt", weCnt, 64);
        check("A_word0", wordAt(0), 64'h0001020304050607);
        check("A_word1", wordAt(1), 64'h08090A0B0C0D0E0F);
        check("A_word63", wordAt(63), 64'hF8F9FAFBFCFDFEFF);
        @(negedge sdClk);
        check("A_done_pulse", done, 0);

        // Same block, lane2 CRC bit flipped
        clearCounts();
        doStart(2'b01, 512, 1, 0);
        driveBlock(4, 512, 1'b0, 2, 1'b0, 0);
        check("B_done", done, 1);
        check("B_errs", {crcErr, timeoutErr, cfgErr}, 3'b100);
        check("B_weCnt", weCnt, 64);
        @(negedge sdClk);
        check("B_crcErr_held", crcErr, 1);

        // 1-lane, 8 zero bytes, inactive lanes random
        clearCounts();
        doStart(2'b00, 8, 1, 0);
        check("C_crcErr_cleared", crcErr, 0);
        driveBlock(1, 8, 1'b1, -1, 1'b0, 2);
        check("C_done", done, 1);
        check("C_crcErr", crcErr, 0);
        check("C_weCnt", weCnt, 1);
        check("C_word0", wordAt(0), 64'h0);

        // 1-lane, bad end bit
        clearCounts();
        doStart(2'b00, 8, 1, 0);
        driveBlock(1, 8, 1'b1, -1, 1'b1, 0);
        check("D_done", done, 1);
        check("D_crcErr", crcErr, 1);
        check("D_weCnt", weCnt, 1);

        // Start-bit timeout of 100 cycles with lanes idle high
        clearCounts();
        doStart(2'b01, 512, 1, 100);
        hit = -1;
        for (int i = 1; i <= 150; i++) begin
            @(negedge sdClk);
            if (done && hit < 0) hit = i;
            if (hit >= 0) break;
        end
        check("E_timeout_cycles", hit, 100);
        check("E_errs", {crcErr, timeoutErr, cfgErr}, 3'b010);
        check("E_weCnt", weCnt, 0);
        check("E_busy", busy, 0);

        // Two blocks with FIFO almost-full at the boundary for 20 cycles
        clearCounts();
        fifoAlmostFull = 1'b1;
        doStart(2'b01, 64, 2, 0);
        driveBlock(4, 64, 1'b0, -1, 1'b0, 1);
        check("F_no_done_blk1", doneCnt, 0);
        check("F_busy_hold", busy, 1);
        stopCnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (sdClkStop) stopCnt++;
            @(negedge sdClk);
        end
        check("F_stop_cycles", stopCnt, 20);
        fifoAlmostFull = 1'b0;
        #1;
        check("F_stop_drop", sdClkStop, 0);
        driveBlock(4, 64, 1'b0, -1, 1'b0, 2);
        check("F_done", done, 1);
        check("F_doneCnt", doneCnt, 1);
        check("F_crcErr", crcErr, 0);
        check("F_weCnt", weCnt, 16);
        check("F_blk2_word0", wordAt(8), 64'h0001020304050607);

        // Illegal configurations
        clearCounts();
        doStart(2'b01, 12, 1, 0);
        check("G_len12_done", done, 1);
        check("G_len12_cfgErr", cfgErr, 1);
        check("G_len12_busy", busy, 0);
        @(negedge sdClk);
        check("G_cfgErr_held", {done, cfgErr}, 2'b01);
        doStart(2'b10, 64, 1, 0);
        check("G_8lane", {done, cfgErr}, 2'b11);
        doStart(2'b01, 0, 1, 0);
        check("G_len0", {done, cfgErr}, 2'b11);
        check("G_weCnt", weCnt, 0);

        // Start while busy is ignored; abort returns to IDLE without done
        clearCounts();
        doStart(2'b01, 512, 1, 0);
        check("I_cfgErr_cleared", cfgErr, 0);
        busWidth = 2'b01; blockLen = 12'd12; start = 1'b1;
        @(negedge sdClk);
        start = 1'b0;
        check("I_ignored_start", {busy, done, cfgErr}, 3'b100);
        abort = 1'b1;
        @(negedge sdClk);
        abort = 1'b0;
        check("I_abort", {busy, done}, 2'b00);
        @(negedge sdClk);
        check("I_abort_doneCnt", doneCnt, 0);

        // Reset in the middle of DATA, right as a word is being written
        clearCounts();
        doStart(2'b01, 512, 1, 0);
        sdDataIn = 4'h0;
        @(negedge sdClk);
        for (int k = 0; k < 32; k++) begin
            sdDataIn = 4'($urandom);
            @(negedge sdClk);
        end
        check("H_we_before", fifoWe, 1);
        sysRst = 1'b1;
        #1;
        check("H_rst_outputs", {fifoWe, busy, done, sdClkStop, crcErr, timeoutErr, cfgErr}, 7'b0);
        check("H_rst_fifoData", fifoData, 0);
        repeat (3) @(negedge sdClk);
        check("H_no_done", doneCnt, 0);
        check("H_weCnt", weCnt, 2);
        sysRst = 1'b0;
        sdDataIn = 4'hF;
        @(negedge sdClk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end
endmodule
